// File: rtl/capture_buf_nch_if.sv
// Bus bundle for capture_buf_nch: arm/sample input, readback request and status.
// The trig signal exists only when CAPTURE_TRIG_EN is defined.
interface capture_buf_nch_if #(
    parameter int CH = 4,
    parameter int DW = 1,
    parameter int AW = 14,
    parameter int SW = 2
);
    logic              arm;
    logic [CH*DW-1:0]  din;
    logic              din_valid;
    logic              rd_en;
    logic [SW-1:0]     rd_sel;
    logic [DW-1:0]     dout;
    logic              dout_valid;
    logic              full;
    logic              empty;
    logic              busy;
    logic [AW:0]       wr_count;

`ifdef CAPTURE_TRIG_EN
    logic              trig;

    modport master (
        output arm, din, din_valid, rd_en, rd_sel, trig,
        input  dout, dout_valid, full, empty, busy, wr_count
    );

    modport slave (
        input  arm, din, din_valid, rd_en, rd_sel, trig,
        output dout, dout_valid, full, empty, busy, wr_count
    );
`else
    modport master (
        output arm, din, din_valid, rd_en, rd_sel,
        input  dout, dout_valid, full, empty, busy, wr_count
    );

    modport slave (
        input  arm, din, din_valid, rd_en, rd_sel,
        output dout, dout_valid, full, empty, busy, wr_count
    );
`endif
endinterface

// File: rtl/capture_buf_nch.sv
// N-channel ADC capture buffer: skip SKIP samples after arm, fill 2**AW words per channel, freeze,
// then read back one channel sequentially. Optional trigger wait is enabled by CAPTURE_TRIG_EN.
module capture_buf_nch #(
    parameter int CH   = 4,
    parameter int DW   = 1,
    parameter int AW   = 14,
    parameter int SKIP = 256,
    parameter int SW   = 2
) (
    input  logic             clk,
    input  logic             rst,
    capture_buf_nch_if.slave bus
);

    localparam int unsigned     DEPTH     = 2 ** AW;
    localparam int              SCW       = (SKIP > 0) ? $clog2(SKIP + 1) : 1;
    localparam logic [AW:0]     LAST_ADDR = (AW + 1)'(DEPTH - 1);
    localparam logic [SCW-1:0]  SKIP_LAST = SCW'((SKIP > 0) ? SKIP - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SKIP  = 3'd1,
        ST_WTRIG = 3'd2,
        ST_CAPT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

`ifdef CAPTURE_TRIG_EN
    localparam state_t AFTER_SKIP = ST_WTRIG;
`else
    localparam state_t AFTER_SKIP = ST_CAPT;
`endif
    localparam state_t START_STATE = (SKIP > 0) ? ST_SKIP : AFTER_SKIP;

    state_t          state_q, state_d;
    logic [AW:0]     wr_count_q, wr_count_d;
    logic [AW:0]     rd_addr_q, rd_addr_d;
    logic [SCW-1:0]  skip_cnt_q, skip_cnt_d;
    logic            full_q, full_d;
    logic [SW-1:0]   sel_q;
    logic            dout_valid_q;

    logic            trig_w;
    logic            wr_en;
    logic            rd_accept;
    logic            empty_w;
    logic            busy_w;
    logic [DW-1:0]   rd_word [CH];
    logic [DW-1:0]   dout_mux;

`ifdef CAPTURE_TRIG_EN
    assign trig_w = bus.trig;
`else
    assign trig_w = 1'b1;
`endif

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wr_count_q   <= '0;
            rd_addr_q    <= '0;
            skip_cnt_q   <= '0;
            full_q       <= 1'b0;
            sel_q        <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_count_q   <= wr_count_d;
            rd_addr_q    <= rd_addr_d;
            skip_cnt_q   <= skip_cnt_d;
            full_q       <= full_d;
            dout_valid_q <= rd_accept;
            if (rd_accept) begin
                sel_q <= bus.rd_sel;
            end
        end
    end

    // Next-state and counter update logic.
    always_comb begin
        state_d    = state_q;
        wr_count_d = wr_count_q;
        rd_addr_d  = rd_addr_q;
        skip_cnt_d = skip_cnt_q;
        full_d     = full_q;

        case (state_q)
            ST_IDLE: begin
                wr_count_d = '0;
                rd_addr_d  = '0;
                skip_cnt_d = '0;
                full_d     = 1'b0;
                if (bus.arm) begin
                    state_d = START_STATE;
                end
            end
            ST_SKIP: begin
                if (bus.din_valid) begin
                    skip_cnt_d = skip_cnt_q + SCW'(1);
                    if (skip_cnt_q == SKIP_LAST) begin
                        state_d = AFTER_SKIP;
                    end
                end
            end
            ST_WTRIG: begin
                if (trig_w) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                state_d = ST_CAPT;
            end
            ST_DONE: begin
                // Re-arm restarts immediately; any concurrent read is dropped.
                if (bus.arm) begin
                    wr_count_d = '0;
                    rd_addr_d  = '0;
                    skip_cnt_d = '0;
                    full_d     = 1'b0;
                    state_d    = START_STATE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (wr_en) begin
            wr_count_d = wr_count_q + (AW + 1)'(1);
            if (wr_count_q == LAST_ADDR) begin
                state_d = ST_DONE;
                full_d  = 1'b1;
            end
        end

        if (rd_accept) begin
            rd_addr_d = rd_addr_q + (AW + 1)'(1);
        end
    end

    // FSM-decoded strobes and status.
    always_comb begin
        busy_w    = (state_q == ST_SKIP) || (state_q == ST_WTRIG) || (state_q == ST_CAPT);
        empty_w   = (state_q != ST_DONE) || (rd_addr_q == wr_count_q);
        // The sample arriving with the trigger is the first one captured.
        wr_en     = bus.din_valid &&
                    ((state_q == ST_CAPT) || ((state_q == ST_WTRIG) && trig_w));
        rd_accept = bus.rd_en && full_q && !empty_w && (state_q == ST_DONE) && !bus.arm;
    end

    // One RAM per channel, all sharing the write and read addresses.
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];
        logic [DW-1:0] rd_q;

        always_ff @(posedge clk) begin
            if (wr_en) begin
                mem[wr_count_q[AW-1:0]] <= bus.din[gi*DW +: DW];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_q <= '0;
            end else if (rd_accept) begin
                rd_q <= mem[rd_addr_q[AW-1:0]];
            end
        end

        assign rd_word[gi] = rd_q;
    end

    // Selects the channel latched with the read; out-of-range selects return zero.
    always_comb begin
        dout_mux = '0;
        for (int c = 0; c < CH; c++) begin
            if (sel_q == SW'(c)) begin
                dout_mux = rd_word[c];
            end
        end
    end

    assign bus.dout       = dout_mux;
    assign bus.dout_valid = dout_valid_q;
    assign bus.full       = full_q;
    assign bus.empty      = empty_w;
    assign bus.busy       = busy_w;
    assign bus.wr_count   = wr_count_q;

endmodule

// File: tb/tb_capture_buf_nch.sv
// Directed bench for capture_buf_nch with CH=4, DW=1, AW=4, SKIP=3; trigger test under CAPTURE_TRIG_EN.
module tb_capture_buf_nch;

    localparam int CH   = 4;
    localparam int DW   = 1;
    localparam int AW   = 4;
    localparam int SKIP = 3;
    localparam int SW   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    logic [3:0] samp  [16];
    logic [3:0] samp2 [16];

    always #5 clk = ~clk;

    capture_buf_nch_if #(.CH(CH), .DW(DW), .AW(AW), .SW(SW)) bus ();

    capture_buf_nch #(.CH(CH), .DW(DW), .AW(AW), .SKIP(SKIP), .SW(SW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.arm       = 1'b0;
        bus.din_valid = 1'b0;
        bus.rd_en     = 1'b0;
`ifdef CAPTURE_TRIG_EN
        bus.trig      = 1'b0;
`endif
    endtask

    task automatic arm_and_skip();
        idle_inputs();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int i = 0; i < SKIP; i++) begin
            bus.din       = 4'hB ^ 4'(i);
            bus.din_valid = 1'b1;
            tick();
        end
        bus.din_valid = 1'b0;
    endtask

    task automatic feed(input logic [3:0] v);
        bus.din       = v;
        bus.din_valid = 1'b1;
        tick();
        bus.din_valid = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.din    = '0;
        bus.rd_sel = '0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", bus.full); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        checks++; if (bus.wr_count !== 5'd0) begin errors++; $display("FAIL reset_wr_count: got %0d want 0", bus.wr_count); end
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_dout_valid: got %b want 0", bus.dout_valid); end
        checks++; if (bus.dout !== 1'b0) begin errors++; $display("FAIL reset_dout: got %b want 0", bus.dout); end
        $display("test_reset done");
    endtask

    task automatic test_capture();
        arm_and_skip();
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL capt_busy_after_skip: got %b want 1", bus.busy); end
        checks++; if (bus.wr_count !== 5'd0) begin errors++; $display("FAIL capt_count_after_skip: got %0d want 0", bus.wr_count); end
        for (int i = 0; i < 15; i++) feed(samp[i]);
        checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL capt_full_at_15: got %b want 0", bus.full); end
        checks++; if (bus.wr_count !== 5'd15) begin errors++; $display("FAIL capt_count_15: got %0d want 15", bus.wr_count); end
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL capt_empty_during: got %b want 1", bus.empty); end
        feed(samp[15]);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL capt_full_at_16: got %b want 1", bus.full); end
        checks++; if (bus.wr_count !== 5'd16) begin errors++; $display("FAIL capt_count_16: got %0d want 16", bus.wr_count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL capt_busy_done: got %b want 0", bus.busy); end
        feed(4'h0);
        feed(4'hF);
        checks++; if (bus.wr_count !== 5'd16) begin errors++; $display("FAIL capt_extra_ignored: got %0d want 16", bus.wr_count); end
        $display("test_capture done: wr_count=%0d", bus.wr_count);
    endtask

    task automatic test_readback();
        for (int i = 0; i < 16; i++) begin
            bus.rd_en  = 1'b1;
            bus.rd_sel = 2'd2;
            tick();
            checks++; if (bus.dout_valid !== 1'b1) begin errors++; $display("FAIL rd2_valid[%0d]: got %b want 1", i, bus.dout_valid); end
            checks++; if (bus.dout !== samp[i][2]) begin errors++; $display("FAIL rd2_data[%0d]: got %b want %b", i, bus.dout, samp[i][2]); end
            $display("read ch2 word %0d: dout=%b", i, bus.dout);
        end
        bus.rd_en = 1'b0;
        checks++; if (bus.empty !== 1'b1) begin errors++; $display("FAIL rd2_empty: got %b want 1", bus.empty); end
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL rd2_17th_valid: got %b want 0", bus.dout_valid); end
        tick();
    endtask

    task automatic test_gaps();
        logic [0:5] skip_pat;
        skip_pat = 6'b100101;
        idle_inputs();
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.din       = 4'h6;
            bus.din_valid = skip_pat[i];
            tick();
        end
        bus.din_valid = 1'b0;
        checks++; if (bus.wr_count !== 5'd0) begin errors++; $display("FAIL gap_skip_count: got %0d want 0", bus.wr_count); end
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 1) begin
                bus.din       = ~samp2[i];
                bus.din_valid = 1'b0;
                tick();
            end
            feed(samp2[i]);
            if (i == 7) begin
                checks++; if (bus.wr_count !== 5'd8) begin errors++; $display("FAIL gap_count_8: got %0d want 8", bus.wr_count); end
            end
        end
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL gap_full: got %b want 1", bus.full); end
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                bus.rd_en = 1'b0;
                tick();
                checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL gap_rd_idle_valid: got %b want 0", bus.dout_valid); end
                checks++; if (bus.dout !== samp2[4][3]) begin errors++; $display("FAIL gap_rd_hold: got %b want %b", bus.dout, samp2[4][3]); end
            end
            bus.rd_en  = 1'b1;
            bus.rd_sel = 2'd3;
            tick();
            checks++; if (bus.dout !== samp2[i][3] || bus.dout_valid !== 1'b1) begin
                errors++; $display("FAIL gap_rd3[%0d]: got %b/%b want %b/1", i, bus.dout, bus.dout_valid, samp2[i][3]);
            end
            $display("read ch3 word %0d: dout=%b", i, bus.dout);
        end
        bus.rd_en = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        arm_and_skip();
        for (int i = 0; i < 5; i++) feed(samp[i]);
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        checks++; if (bus.wr_count !== 5'd5 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL abort_arm_in_capt: got cnt=%0d busy=%b want 5/1", bus.wr_count, bus.busy);
        end
        feed(samp[5]);
        feed(samp[6]);
        checks++; if (bus.wr_count !== 5'd7) begin errors++; $display("FAIL abort_count_7: got %0d want 7", bus.wr_count); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (bus.wr_count !== 5'd0 || bus.busy !== 1'b0) begin
            errors++; $display("FAIL abort_rst: got cnt=%0d busy=%b want 0/0", bus.wr_count, bus.busy);
        end
        arm_and_skip();
        for (int i = 0; i < 16; i++) feed(samp[i]);
        bus.rd_en  = 1'b1;
        bus.rd_sel = 2'd1;
        tick();
        checks++; if (bus.dout_valid !== 1'b1 || bus.dout !== samp[0][1]) begin
            errors++; $display("FAIL abort_first_read: got %b/%b want %b/1", bus.dout, bus.dout_valid, samp[0][1]);
        end
        bus.arm = 1'b1;
        tick();
        bus.arm   = 1'b0;
        bus.rd_en = 1'b0;
        checks++; if (bus.dout_valid !== 1'b0) begin errors++; $display("FAIL abort_arm_rd_valid: got %b want 0", bus.dout_valid); end
        checks++; if (bus.busy !== 1'b1 || bus.full !== 1'b0 || bus.wr_count !== 5'd0) begin
            errors++; $display("FAIL abort_rearm: got busy=%b full=%b cnt=%0d want 1/0/0", bus.busy, bus.full, bus.wr_count);
        end
        checks++; if (bus.dout !== samp[0][1]) begin errors++; $display("FAIL abort_dout_hold: got %b want %b", bus.dout, samp[0][1]); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("test_abort done");
    endtask

`ifdef CAPTURE_TRIG_EN
    task automatic test_trig();
        arm_and_skip();
        for (int i = 0; i < 10; i++) feed(4'h9);
        checks++; if (bus.wr_count !== 5'd0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL trig_wait: got cnt=%0d busy=%b want 0/1", bus.wr_count, bus.busy);
        end
        bus.trig = 1'b1;
        feed(samp[0]);
        bus.trig = 1'b0;
        checks++; if (bus.wr_count !== 5'd1) begin errors++; $display("FAIL trig_first: got %0d want 1", bus.wr_count); end
        for (int i = 1; i < 16; i++) feed(samp[i]);
        checks++; if (bus.full !== 1'b1) begin errors++; $display("FAIL trig_full: got %b want 1", bus.full); end
        bus.rd_en  = 1'b1;
        bus.rd_sel = 2'd1;
        tick();
        bus.rd_en = 1'b0;
        checks++; if (bus.dout !== samp[0][1] || bus.dout_valid !== 1'b1) begin
            errors++; $display("FAIL trig_read0: got %b/%b want %b/1", bus.dout, bus.dout_valid, samp[0][1]);
        end
        $display("test_trig done");
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        samp  = '{4'h0, 4'h4, 4'hB, 4'h6, 4'h3, 4'hC, 4'h5, 4'hE,
                  4'h7, 4'h1, 4'hD, 4'h8, 4'h2, 4'hF, 4'h9, 4'hA};
        for (int i = 0; i < 16; i++) samp2[i] = samp[15 - i];
        test_reset();
        test_capture();
        test_readback();
        test_gaps();
        test_abort();
`ifdef CAPTURE_TRIG_EN
        test_trig();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
